// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Executes MULTU/MULT/DIVU/DIV over WIDTH iterations plus one fix-up cycle and
// keeps the result in HI/LO until the next operation completes.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start_i       request an operation (sampled only while idle)
//   op_i          00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a_i, b_i      rs / rt operands
//   busy_o        operation in progress (pipeline stall)
//   done_o        one-cycle pulse after HI/LO update
//   div_by_zero_o last completed divide had a zero divisor
//   hi_o, lo_o    HI / LO registers
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;       // product / quotient sign
  logic               a_neg_q, a_neg_d;   // remainder sign
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;   // multiplicand addend / divisor
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;   // original dividend for divide-by-zero HI
  logic [WIDTH:0]     acc_hi_q, acc_hi_d; // product upper half / partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d; // multiplier bits / dividend -> quotient
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_flag_q, dbz_flag_d;

  // Operand magnitudes at capture.
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = op_i[0] & a_i[WIDTH-1];
    b_sgn = op_i[0] & b_i[WIDTH-1];
    a_mag = a_sgn ? -a_i : a_i;
    b_mag = b_sgn ? -b_i : b_i;
  end

  // Iteration datapath.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     rem_mag;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    mul_sum   = acc_lo_q[0] ? (acc_hi_q + {1'b0, b_mag_q}) : acc_hi_q;
    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    // Bit WIDTH set means the trial subtraction went negative: restore.
    div_trial = div_shift - {1'b0, b_mag_q};
    prod      = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    prod_fix  = neg_q ? -prod : prod;
    rem_mag   = acc_hi_q[WIDTH-1:0];
    quo_fix   = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix   = a_neg_q ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    a_neg_d    = a_neg_q;
    dbz_d      = dbz_q;
    b_mag_d    = b_mag_q;
    a_raw_d    = a_raw_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_flag_d = dbz_flag_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          cnt_d    = CntW'(WIDTH - 1);
          is_div_d = op_i[1];
          neg_d    = a_sgn ^ b_sgn;
          a_neg_d  = a_sgn;
          dbz_d    = op_i[1] & (b_i == '0);
          b_mag_d  = b_mag;
          a_raw_d  = a_i;
          acc_hi_d = '0;
          acc_lo_d = a_mag;
        end
      end
      StRun: begin
        if (is_div_q) begin
          if (div_trial[WIDTH]) begin
            acc_hi_d = div_shift;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_hi_d = div_trial;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        dbz_flag_d = dbz_q;
        if (dbz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      dbz_q      <= 1'b0;
      b_mag_q    <= '0;
      a_raw_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      a_neg_q    <= a_neg_d;
      dbz_q      <= dbz_d;
      b_mag_q    <= b_mag_d;
      a_raw_q    <= a_raw_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_flag_q <= dbz_flag_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_flag_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
